btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_pkg.sv | 24 ++
 rtl/btn_chan.sv | 134 +++++++++++++
 rtl/btn_debounce.sv | 35 +++
 tb/tb_btn_debounce.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: repeat-state encoding,
// counter width, parameter defaults and a saturating increment helper.
package btn_pkg;

  localparam int unsigned NUM_BTN           = 5;
  localparam int unsigned CNT_W             = 20;

  localparam int unsigned DB_CYCLES_DEF     = 1000;
  localparam int unsigned REPEAT_DELAY_DEF  = 50000;
  localparam int unsigned REPEAT_PERIOD_DEF = 10000;
  localparam logic [NUM_BTN-1:0] REPEAT_EN_DEF = 5'b00000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: two-flop synchronizer, debounce counter with
// registered level and edge pulses, and the auto-repeat state machine.
module btn_chan
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter logic        RPT_EN        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_p
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             rise, fall;
  logic             rpt_fire;
  rpt_state_e       state_q;
  logic [CNT_W-1:0] rpt_cnt_q;
  logic [31:0]      rpt_cnt_inc;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing samples; once the count has reached
  // DB_CYCLES and the input still disagrees, flip the level and restart.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (32'(db_cnt_q) >= DB_CYCLES) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = sat_inc(db_cnt_q);
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  // Decide whether the repeat timer expires on this edge; a release wins.
  assign rpt_cnt_inc = 32'(rpt_cnt_q) + 32'd1;
  always_comb begin
    rpt_fire = 1'b0;
    case (state_q)
      ST_DELAY:  rpt_fire = (rpt_cnt_inc == REPEAT_DELAY);
      ST_REPEAT: rpt_fire = (rpt_cnt_inc == REPEAT_PERIOD);
      default:   rpt_fire = 1'b0;
    endcase
    if (fall) begin
      rpt_fire = 1'b0;
    end
  end

  // Auto-repeat FSM: arm on a press, first pulse after the delay, then
  // periodic pulses until the button is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rpt_cnt_q <= '0;
    end else if (fall) begin
      state_q   <= ST_IDLE;
      rpt_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rpt_cnt_q <= '0;
          if (rise && RPT_EN) begin
            state_q <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (rpt_fire) begin
            state_q   <= ST_REPEAT;
            rpt_cnt_q <= '0;
          end else begin
            rpt_cnt_q <= sat_inc(rpt_cnt_q);
          end
        end
        ST_REPEAT: begin
          if (rpt_fire) begin
            rpt_cnt_q <= '0;
          end else begin
            rpt_cnt_q <= sat_inc(rpt_cnt_q);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          rpt_cnt_q <= '0;
        end
      endcase
    end
  end

  assign press_d   = rise | rpt_fire;
  assign release_d = fall;

  // Debounced level, its counter and the registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_p = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Five independent debounced push-button channels with optional auto-repeat.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned        DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned        REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned        REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter logic [NUM_BTN-1:0] REPEAT_EN     = REPEAT_EN_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  // One channel per button; nothing is shared between them.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_chan #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .RPT_EN       (REPEAT_EN[i])
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn[i]),
      .level    (btn_level[i]),
      .press    (btn_press[i]),
      .release_p(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random button activity,
// all compared against a behavioural model of the debounce/repeat rules.
module tb_btn_debounce;

  localparam int          DB  = 4;
  localparam int          RD  = 10;
  localparam int          RP  = 3;
  localparam logic [4:0]  REN = 5'b00100;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] btn   = 5'b0;
  logic [4:0] btn_level, btn_press, btn_release;

  int tests_run    = 0;
  int tests_failed = 0;

  btn_debounce #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_EN    (REN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         edge_n = 0;
  logic [4:0] hist[$];
  int         run[5];
  bit         m_lvl[5];
  int         rise_edge[5];
  logic [4:0] m_level, m_press, m_release;

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 5; i++) begin
      run[i]       = 0;
      m_lvl[i]     = 1'b0;
      rise_edge[i] = 0;
    end
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
  endtask

  // The core sees each raw sample two edges late; a level change needs
  // DB+1 consecutive late samples disagreeing with the current level.
  // Repeats fire RD edges after the rise and every RP edges thereafter.
  task automatic model_edge(input logic [4:0] b);
    logic [4:0] sv;
    int t;
    hist.push_back(b);
    if (hist.size() > 3) void'(hist.pop_front());
    sv = (hist.size() == 3) ? hist[0] : 5'b0;
    m_press   = '0;
    m_release = '0;
    for (int i = 0; i < 5; i++) begin
      if (sv[i] != m_lvl[i]) begin
        run[i]++;
        if (run[i] == DB + 1) begin
          m_lvl[i] = ~m_lvl[i];
          run[i]   = 0;
          if (m_lvl[i]) begin
            m_press[i]   = 1'b1;
            rise_edge[i] = edge_n;
          end else begin
            m_release[i] = 1'b1;
          end
        end
      end else begin
        run[i] = 0;
      end
      if (REN[i] && m_lvl[i] && !m_press[i]) begin
        t = edge_n - rise_edge[i];
        if (t == RD || (t > RD && ((t - RD) % RP) == 0)) m_press[i] = 1'b1;
      end
      m_level[i] = m_lvl[i];
    end
  endtask

  task automatic step(input logic [4:0] b);
    btn = b;
    @(posedge clk);
    edge_n++;
    model_edge(b);
    #1;
    check_eq("level",   btn_level,   m_level);
    check_eq("press",   btn_press,   m_press);
    check_eq("release", btn_release, m_release);
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    #1;
    check_eq("rst_level",   btn_level,   5'b0);
    check_eq("rst_press",   btn_press,   5'b0);
    check_eq("rst_release", btn_release, 5'b0);
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] cur;
    logic [4:0] exp_p;
    model_reset();
    #2;

    // Single button held: level and press rise at edge 6
    apply_reset(2);
    for (int k = 0; k < 10; k++) begin
      step(5'b00001);
      if (k == 5) check_eq("r28_level5", btn_level, 5'b00000);
      if (k == 6) begin
        check_eq("r28_press6", btn_press, 5'b00001);
        check_eq("r28_level6", btn_level, 5'b00001);
      end
      if (k == 7) check_eq("r28_press7", btn_press, 5'b00000);
    end

    // Short glitch leaves everything quiet
    apply_reset(2);
    for (int k = 0; k < 23; k++) begin
      step((k < 3) ? 5'b00010 : 5'b00000);
      check_eq("r29_quiet", btn_level | btn_press | btn_release, 5'b00000);
    end

    // Auto-repeat on button 2, then release
    apply_reset(2);
    for (int k = 0; k < 41; k++) begin
      step((k < 30) ? 5'b00100 : 5'b00000);
      exp_p = (k inside {6, 16, 19, 22, 25, 28, 31, 34}) ? 5'b00100 : 5'b00000;
      check_eq("r30_press", btn_press, exp_p);
      if (k == 36) check_eq("r30_release", btn_release, 5'b00100);
    end

    // All buttons at once
    apply_reset(2);
    for (int k = 0; k < 8; k++) begin
      step(5'b11111);
      if (k == 6) check_eq("r31_press", btn_press, 5'b11111);
    end

    // Reset during debounce with button 3 held
    apply_reset(2);
    for (int k = 0; k < 5; k++) step(5'b01000);
    apply_reset(1);
    for (int k = 0; k < 9; k++) begin
      step(5'b01000);
      if (k == 5) check_eq("r32_press5", btn_press, 5'b00000);
      if (k == 6) check_eq("r32_press6", btn_press, 5'b01000);
    end

    // Reset while repeating with level high
    apply_reset(2);
    for (int k = 0; k < 20; k++) step(5'b00100);
    apply_reset(1);
    for (int k = 0; k < 20; k++) step(5'b00100);

    // Random activity, with one reset in the middle
    apply_reset(2);
    cur = 5'b0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 9) == 0) cur[i] = ~cur[i];
      end
      if (n == 300) apply_reset(1);
      step(cur);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
